// File: rtl/bit_stuffer.sv
// ----------------------------------------------------------------------------
// bit_stuffer
//   USB transmit bit-stuffing stage, sitting between the serializer and nrzi.
//   After every MAX_RUN consecutive 1s it inserts a 0 and stalls the serializer
//   for that cycle. It also keeps a saturating count of the bits inserted into
//   the current (or most recent) packet, which nrzi uses to extend its
//   packet-length limit.
//
// Ports
//   clk             in   1      system clock, rising edge
//   rst_b           in   1      asynchronous active-low reset
//   bstr_in         in   1      serial data bit from the serializer
//   bstr_in_ready   in   2      packet type: 00 none, 01 token, 10 data, 11 handshake
//   stall           out  1      combinational; serializer holds its inputs this cycle
//   bstr_out        out  1      stuffed serial bit to nrzi (registered)
//   bstr_out_ready  out  2      packet type for bstr_out, 00 when idle (registered)
//   stuffed_out     out  CNT_W  bits inserted into the current/last packet (registered)
// ----------------------------------------------------------------------------
module bit_stuffer #(
    parameter int unsigned MAX_RUN = 6,
    parameter int unsigned CNT_W   = 6
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             bstr_in,
    input  logic [1:0]       bstr_in_ready,
    output logic             stall,
    output logic             bstr_out,
    output logic [1:0]       bstr_out_ready,
    output logic [CNT_W-1:0] stuffed_out
);

    localparam int unsigned     RUN_W   = $clog2(MAX_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    typedef enum logic [0:0] {
        StIdle,
        StPass
    } state_e;

    state_e           state_q;
    logic [RUN_W-1:0] run_q;    // consecutive 1s already emitted in this packet
    logic [1:0]       ptype_q;  // packet type latched on the first bit

    // Depends on registers only, so the serializer never sees a combinational
    // path back from its own outputs.
    assign stall = (state_q == StPass) && (run_q == RUN_MAX);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q        <= StIdle;
            run_q          <= '0;
            ptype_q        <= 2'b00;
            bstr_out       <= 1'b0;
            bstr_out_ready <= 2'b00;
            stuffed_out    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    bstr_out       <= 1'b0;
                    bstr_out_ready <= 2'b00;
                    run_q          <= '0;
                    if (bstr_in_ready != 2'b00) begin
                        ptype_q        <= bstr_in_ready;
                        bstr_out       <= bstr_in;
                        bstr_out_ready <= bstr_in_ready;
                        run_q          <= bstr_in ? RUN_ONE : '0;
                        stuffed_out    <= '0;
                        state_q        <= StPass;
                    end
                end
                StPass: begin
                    if (run_q == RUN_MAX) begin
                        // Stuffed 0 goes out even when the packet has already
                        // ended, so a trailing run of 1s is still terminated.
                        bstr_out       <= 1'b0;
                        bstr_out_ready <= ptype_q;
                        run_q          <= '0;
                        if (stuffed_out != CNT_SAT) begin
                            stuffed_out <= stuffed_out + 1'b1;
                        end
                    end else if (bstr_in_ready != 2'b00) begin
                        // Mid-packet tag changes are accepted as valid but ignored.
                        bstr_out       <= bstr_in;
                        bstr_out_ready <= ptype_q;
                        run_q          <= bstr_in ? run_q + 1'b1 : '0;
                    end else begin
                        // stuffed_out is left alone so nrzi sees the final count.
                        bstr_out       <= 1'b0;
                        bstr_out_ready <= 2'b00;
                        run_q          <= '0;
                        state_q        <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_stuffer.sv
module tb_bit_stuffer;

    localparam int MAX_RUN = 6;
    localparam int CNT_W   = 6;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_b;
    logic             bstr_in;
    logic [1:0]       bstr_in_ready;
    logic             stall;
    logic             bstr_out;
    logic [1:0]       bstr_out_ready;
    logic [CNT_W-1:0] stuffed_out;

    bit_stuffer #(
        .MAX_RUN(MAX_RUN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .bstr_in       (bstr_in),
        .bstr_in_ready (bstr_in_ready),
        .stall         (stall),
        .bstr_out      (bstr_out),
        .bstr_out_ready(bstr_out_ready),
        .stuffed_out   (stuffed_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus and captured traffic for one packet.
    bit         in_bits[$];
    bit         out_bits[$];
    logic [1:0] out_tags[$];
    int         out_cnt[$];
    int         stall_seen;
    int         drain_ticks;

    // Reference stream computed from the stuffing rule.
    bit exp_bits[$];
    int exp_cnt[$];
    int exp_stuffs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bstr_out_ready != 2'b00) begin
            out_bits.push_back(bstr_out);
            out_tags.push_back(bstr_out_ready);
            out_cnt.push_back(int'(stuffed_out));
        end
        if (stall) stall_seen++;
    endtask

    // Serializer behaviour: present each bit, hold it while stall is high,
    // then drop ready and run until the stuffer goes idle.
    task automatic send_packet(input logic [1:0] tag, input bit scramble);
        int guard;
        out_bits.delete();
        out_tags.delete();
        out_cnt.delete();
        stall_seen  = 0;
        drain_ticks = 0;
        foreach (in_bits[i]) begin
            bstr_in       = in_bits[i];
            bstr_in_ready = (scramble && i > 0) ? 2'($urandom_range(1, 3)) : tag;
            guard = 0;
            while (stall && guard < 4) begin
                tick();
                guard++;
            end
            if (guard >= 4) check("stall_bound", 64'(guard), 64'd1);
            tick();
        end
        bstr_in       = 1'b0;
        bstr_in_ready = 2'b00;
        do begin
            tick();
            drain_ticks++;
        end while (bstr_out_ready != 2'b00 && drain_ticks < 4);
        check("drain_ready", 64'(bstr_out_ready), 64'd0);
        check("drain_bit", 64'(bstr_out), 64'd0);
        check("drain_stall", 64'(stall), 64'd0);
    endtask

    task automatic build_model();
        int run;
        run        = 0;
        exp_stuffs = 0;
        exp_bits.delete();
        exp_cnt.delete();
        foreach (in_bits[i]) begin
            exp_bits.push_back(in_bits[i]);
            exp_cnt.push_back(exp_stuffs > CNT_SAT ? CNT_SAT : exp_stuffs);
            run = in_bits[i] ? run + 1 : 0;
            if (run == MAX_RUN) begin
                exp_stuffs++;
                exp_bits.push_back(1'b0);
                exp_cnt.push_back(exp_stuffs > CNT_SAT ? CNT_SAT : exp_stuffs);
                run = 0;
            end
        end
    endtask

    task automatic check_stream(input string name, input logic [1:0] tag);
        int n;
        int bad_bit;
        int bad_cnt;
        int bad_tag;
        int fin;
        build_model();
        fin = exp_stuffs > CNT_SAT ? CNT_SAT : exp_stuffs;
        check({name, "_len"}, 64'(out_bits.size()), 64'(exp_bits.size()));
        n       = out_bits.size() < exp_bits.size() ? out_bits.size() : exp_bits.size();
        bad_bit = 0;
        bad_cnt = 0;
        bad_tag = 0;
        for (int i = 0; i < n; i++) begin
            if (out_bits[i] != exp_bits[i]) bad_bit++;
            if (out_cnt[i] != exp_cnt[i]) bad_cnt++;
            if (out_tags[i] != tag) bad_tag++;
        end
        check({name, "_bits_wrong"}, 64'(bad_bit), 64'd0);
        check({name, "_count_trace_wrong"}, 64'(bad_cnt), 64'd0);
        check({name, "_tags_wrong"}, 64'(bad_tag), 64'd0);
        check({name, "_stalls"}, 64'(stall_seen), 64'(exp_stuffs));
        check({name, "_final_count"}, 64'(stuffed_out), 64'(fin));
    endtask

    typedef struct {
        string       name;
        logic [1:0]  tag;
        int          n;
        logic [31:0] bits;      // bit i is sent i-th
        int          exp_len;
        logic [63:0] exp_out;   // bit i is the i-th bit out
        int          exp_stuffed;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        logic [63:0] got;
        int          bad_tag;
        in_bits.delete();
        for (int i = 0; i < v.n; i++) in_bits.push_back(v.bits[i]);
        send_packet(v.tag, 1'b0);
        got     = '0;
        bad_tag = 0;
        foreach (out_bits[i]) begin
            if (i < 64) got[i] = out_bits[i];
            if (out_tags[i] != v.tag) bad_tag++;
        end
        check({v.name, "_vlen"}, 64'(out_bits.size()), 64'(v.exp_len));
        check({v.name, "_vout"}, got, v.exp_out);
        check({v.name, "_vtags_wrong"}, 64'(bad_tag), 64'd0);
        check({v.name, "_vstuffed"}, 64'(stuffed_out), 64'(v.exp_stuffed));
        check({v.name, "_vstalls"}, 64'(stall_seen), 64'(v.exp_stuffed));
        check_stream(v.name, v.tag);
    endtask

    initial begin
        int guard;
        int seen;
        logic [1:0] tag;
        int len;

        vecs[0] = '{"t1_token",   2'b01, 8,  32'h000000FF, 9,  64'h1BF,   1};
        vecs[1] = '{"t2_data",    2'b10, 7,  32'h0000005F, 7,  64'h05F,   0};
        vecs[2] = '{"t3_hshake",  2'b11, 7,  32'h0000007E, 8,  64'h07E,   1};
        vecs[3] = '{"t4_data18",  2'b10, 18, 32'h0003FFFF, 21, 64'hFDFBF, 3};
        vecs[4] = '{"six_then_0", 2'b01, 7,  32'h0000003F, 8,  64'h03F,   1};

        rst_b         = 1'b0;
        bstr_in       = 1'b0;
        bstr_in_ready = 2'b00;
        #12;
        check("reset_ready", 64'(bstr_out_ready), 64'd0);
        check("reset_bit", 64'(bstr_out), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_stuffed", 64'(stuffed_out), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted during the second stall of a long run of 1s.
        bstr_in       = 1'b1;
        bstr_in_ready = 2'b01;
        guard         = 0;
        seen          = 0;
        while (guard < 40) begin
            if (stall) begin
                seen++;
                if (seen == 2) break;
            end
            tick();
            guard++;
        end
        check("t5_second_stall", 64'(seen), 64'd2);
        check("t5_pre_stuffed", 64'(stuffed_out), 64'd1);
        rst_b = 1'b0;
        #1;
        check("t5_rst_ready", 64'(bstr_out_ready), 64'd0);
        check("t5_rst_stall", 64'(stall), 64'd0);
        check("t5_rst_stuffed", 64'(stuffed_out), 64'd0);
        check("t5_rst_bit", 64'(bstr_out), 64'd0);
        bstr_in_ready = 2'b00;
        bstr_in       = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        tick();
        run_vec(vecs[0]);

        // Two packets with the minimum one-cycle gap; run must not carry over.
        in_bits = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        send_packet(2'b10, 1'b0);
        check_stream("t6_pkt1", 2'b10);
        check("t6_gap_cycles", 64'(drain_ticks), 64'd1);
        check("t6_gap_stuffed", 64'(stuffed_out), 64'd1);
        in_bits = '{1, 1, 1, 1};
        send_packet(2'b01, 1'b0);
        check_stream("t6_pkt2", 2'b01);
        check("t6_pkt2_first_count", 64'(out_cnt.size() > 0 ? out_cnt[0] : -1), 64'd0);

        // Saturation of the inserted-bit counter.
        in_bits.delete();
        for (int i = 0; i < 65 * MAX_RUN; i++) in_bits.push_back(1'b1);
        send_packet(2'b10, 1'b0);
        check_stream("sat", 2'b10);

        // Randomised packets, some with a wandering tag after the first bit.
        for (int p = 0; p < 40; p++) begin
            tag = 2'($urandom_range(1, 3));
            len = $urandom_range(1, 40);
            in_bits.delete();
            for (int i = 0; i < len; i++) in_bits.push_back($urandom_range(0, 7) != 0);
            send_packet(tag, $urandom_range(0, 3) == 0);
            check_stream("rand", tag);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
